axi_sram_slave: RTL

- AXI4 slave (responder) that bridges the AR/R/AW/W/B channels from the interconnect onto a single-port, synchronous, byte-maskable SRAM macro.
- It is the far end of the CPU-side AXI master. It services one transaction at a time, with INCR bursts of up to 16 beats.
- One instance sits in front of each instruction or data SRAM.

---
 rtl/axi_sram_slave_if.sv | 67 ++++++
 rtl/axi_sram_slave.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI4 AR/R/AW/W/B channel bundle between the interconnect master and the SRAM slave.
interface axi_sram_slave_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;

    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [LEN_W-1:0]  AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;

    logic [DATA_W-1:0] WDATA;
    logic [3:0]        WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;

    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave servicing one INCR burst at a time against a single-port, byte-maskable SRAM.
// Reads take two cycles per beat (fetch, then present); writes commit one beat per cycle.
module axi_sram_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst,
    axi_sram_slave_if.slave   axi,
    output logic              SRAM_CEB,
    output logic              SRAM_WEB,
    output logic [31:0]       SRAM_BWEB,
    output logic [MEM_AW-1:0] SRAM_A,
    output logic [31:0]       SRAM_DI,
    input  logic [31:0]       SRAM_DO
);
    typedef enum logic [2:0] {IDLE, R_FETCH, R_DATA, W_DATA, B_RESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t            state, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              over_q, over_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rdy_en_q;
    logic              last_beat;

    // Size/burst fields and address bits outside the SRAM window carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{axi.ARSIZE, axi.ARBURST, axi.AWSIZE, axi.AWBURST,
                           axi.ARADDR[ADDR_W-1:MEM_AW+2], axi.ARADDR[1:0],
                           axi.AWADDR[ADDR_W-1:MEM_AW+2], axi.AWADDR[1:0]};

    assign last_beat = (beat_q == len_q);
    assign axi.RID   = id_q;
    assign axi.BID   = id_q;
    assign axi.RRESP = RESP_OKAY;
    assign axi.BRESP = bresp_q;
    assign SRAM_A    = addr_q;
    assign SRAM_DI   = axi.WDATA;

    // NOTE: every signal written below gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        id_d        = id_q;
        over_d      = over_q;
        bresp_d     = bresp_q;
        axi.ARREADY = 1'b0;
        axi.AWREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RLAST   = 1'b0;
        axi.RDATA   = '0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        SRAM_CEB    = 1'b1;
        SRAM_WEB    = 1'b1;
        SRAM_BWEB   = '1;

        unique case (state)
            IDLE: begin
                // Reads take priority when both address channels request together.
                axi.ARREADY = rdy_en_q;
                axi.AWREADY = rdy_en_q & ~axi.ARVALID;
                if (rdy_en_q && axi.ARVALID) begin
                    id_d    = axi.ARID;
                    addr_d  = axi.ARADDR[MEM_AW+1:2];
                    len_d   = axi.ARLEN;
                    beat_d  = '0;
                    state_d = R_FETCH;
                end else if (rdy_en_q && axi.AWVALID) begin
                    id_d    = axi.AWID;
                    addr_d  = axi.AWADDR[MEM_AW+1:2];
                    len_d   = axi.AWLEN;
                    beat_d  = '0;
                    over_d  = 1'b0;
                    state_d = W_DATA;
                end
            end
            R_FETCH: begin
                SRAM_CEB = 1'b0;
                state_d  = R_DATA;
            end
            R_DATA: begin
                // The macro holds DO while deselected, so RDATA stays stable under backpressure.
                axi.RVALID = 1'b1;
                axi.RDATA  = SRAM_DO;
                axi.RLAST  = last_beat;
                if (axi.RREADY) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + MEM_AW'(1);
                        beat_d  = beat_q + LEN_W'(1);
                        state_d = R_FETCH;
                    end
                end
            end
            W_DATA: begin
                axi.WREADY = 1'b1;
                if (axi.WVALID) begin
                    SRAM_CEB = 1'b0;
                    SRAM_WEB = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        SRAM_BWEB[8*k +: 8] = {8{~axi.WSTRB[k]}};
                    end
                    addr_d = addr_q + MEM_AW'(1);
                    beat_d = beat_q + LEN_W'(1);
                    // Once the announced length is used up, any later beat is an overrun.
                    if (last_beat && !axi.WLAST) begin
                        over_d = 1'b1;
                    end
                    if (axi.WLAST) begin
                        bresp_d = (!over_q && last_beat) ? RESP_OKAY : RESP_SLVERR;
                        state_d = B_RESP;
                    end
                end
            end
            B_RESP: begin
                axi.BVALID = 1'b1;
                if (axi.BREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            id_q     <= '0;
            over_q   <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rdy_en_q <= 1'b0;
        end else begin
            state    <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            id_q     <= id_d;
            over_q   <= over_d;
            bresp_q  <= bresp_d;
            rdy_en_q <= 1'b1;
        end
    end
endmodule
